// File: rtl/ec_prod_sum_pkg.sv
// Shared Q32.32 field widths and the sign-magnitude result type for the product-sum datapath.
// Pure declarations; no timing or flow-control content.
package ec_prod_sum_pkg;
    localparam int INT_W  = 32;
    localparam int FRAC_W = 32;
    localparam int Q_W    = INT_W + FRAC_W;
    localparam int PROD_W = 2 * Q_W;
    localparam int WORD_W = 16;

    typedef struct packed {
        logic           sign;
        logic [Q_W-1:0] mag;
    } sm_t;
endpackage

// File: rtl/ec_sm_to_q.sv
// Two's-complement Q64.64 accumulator to sign-magnitude Q32.32: truncate or round half away
// from zero, saturate on integer overflow, no negative zero. Combinational, no flow control.
module ec_sm_to_q
    import ec_prod_sum_pkg::*;
#(
    parameter int ACC_W = PROD_W + 9
) (
    input  logic [ACC_W-1:0] i_sum,
    input  logic             i_trunc,
    output sm_t              o_res,
    output logic             o_ovf
);
    localparam int QW = ACC_W - FRAC_W + 1;

    logic             w_neg;
    logic [ACC_W-1:0] w_abs;
    logic [QW-1:0]    w_q;
    logic [Q_W-1:0]   w_mag;

    assign w_neg = i_sum[ACC_W-1];
    assign w_abs = w_neg ? -i_sum : i_sum;

    // Rounding on the magnitude gives half-away-from-zero for both signs; spare top bit keeps the carry.
    assign w_q   = {1'b0, w_abs[ACC_W-1:FRAC_W]} + QW'(~i_trunc & w_abs[FRAC_W-1]);
    assign o_ovf = |w_q[QW-1:Q_W];
    assign w_mag = o_ovf ? {Q_W{1'b1}} : w_q[Q_W-1:0];

    assign o_res.sign = w_neg & (|w_mag);
    assign o_res.mag  = w_mag;
endmodule

// File: rtl/ec_prod_sum.sv
// Exact signed Q32.32 dot product: multiply, accumulate, convert; result 3 edges after the last pair.
// No backpressure: a pair is accepted every cycle datavalid_in is high.
module ec_prod_sum
    import ec_prod_sum_pkg::*;
#(
    parameter int ACC_GUARD = 8
) (
    input  logic              s_clk,
    input  logic              clr,
    input  logic              datavalid_in,
    input  logic              clear_ena,
    input  logic              trunc_ena,
    input  logic              binvalA_sign,
    input  logic [WORD_W-1:0] binvalA_1_,
    input  logic [WORD_W-1:0] binvalA_2_,
    input  logic [WORD_W-1:0] binvalA_3_,
    input  logic [WORD_W-1:0] binvalA_4_,
    input  logic              binvalB_sign,
    input  logic [WORD_W-1:0] binvalB_1_,
    input  logic [WORD_W-1:0] binvalB_2_,
    input  logic [WORD_W-1:0] binvalB_3_,
    input  logic [WORD_W-1:0] binvalB_4_,
    output logic              sign_out,
    output logic [WORD_W-1:0] bin_out_1_,
    output logic [WORD_W-1:0] bin_out_2_,
    output logic [WORD_W-1:0] bin_out_3_,
    output logic [WORD_W-1:0] bin_out_4_,
    output logic              result_valid,
    output logic              overflow
);
    localparam int ACC_W = PROD_W + 1 + ACC_GUARD;

    logic [Q_W-1:0]    w_a_mag, w_b_mag;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_prod_ext, w_term, w_base, w_sum;
    sm_t               w_res;
    logic              w_ovf;

    logic              r_vld1, r_last1, r_trunc1, r_psign;
    logic [PROD_W-1:0] r_prod;
    logic              r_vld2, r_trunc2;
    logic [ACC_W-1:0]  r_acc, r_sum;

    assign w_a_mag = {binvalA_4_, binvalA_3_, binvalA_2_, binvalA_1_};
    assign w_b_mag = {binvalB_4_, binvalB_3_, binvalB_2_, binvalB_1_};
    assign w_prod  = PROD_W'(w_a_mag) * PROD_W'(w_b_mag);

    assign w_prod_ext = ACC_W'(r_prod);
    assign w_term     = r_psign ? -w_prod_ext : w_prod_ext;
    // A standalone clear empties the accumulator, but a pair already in stage 1 still lands on top of it.
    assign w_base     = (clear_ena & ~datavalid_in) ? '0 : r_acc;
    assign w_sum      = w_base + w_term;

    ec_sm_to_q #(.ACC_W(ACC_W)) u_sm_to_q (
        .i_sum   (r_sum),
        .i_trunc (r_trunc2),
        .o_res   (w_res),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge s_clk) begin
        if (clr) begin
            r_vld1       <= 1'b0;
            r_last1      <= 1'b0;
            r_trunc1     <= 1'b0;
            r_psign      <= 1'b0;
            r_prod       <= '0;
            r_vld2       <= 1'b0;
            r_trunc2     <= 1'b0;
            r_acc        <= '0;
            r_sum        <= '0;
            sign_out     <= 1'b0;
            bin_out_1_   <= '0;
            bin_out_2_   <= '0;
            bin_out_3_   <= '0;
            bin_out_4_   <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_vld1 <= datavalid_in;
            if (datavalid_in) begin
                r_prod   <= w_prod;
                r_psign  <= binvalA_sign ^ binvalB_sign;
                r_last1  <= clear_ena;
                r_trunc1 <= trunc_ena;
            end

            r_vld2 <= r_vld1 & r_last1;
            if (r_vld1 && r_last1) begin
                r_sum    <= w_sum;
                r_trunc2 <= r_trunc1;
                r_acc    <= '0;
            end else if (r_vld1) begin
                r_acc <= w_sum;
            end else begin
                r_acc <= w_base;
            end

            result_valid <= r_vld2;
            if (r_vld2) begin
                sign_out   <= w_res.sign;
                {bin_out_4_, bin_out_3_, bin_out_2_, bin_out_1_} <= w_res.mag;
                overflow   <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_ec_prod_sum.sv
// Directed-vector bench for ec_prod_sum with a queue scoreboard checked by an independent monitor.
module tb_ec_prod_sum;
    logic        s_clk = 1'b0;
    logic        clr, datavalid_in, clear_ena, trunc_ena;
    logic        binvalA_sign, binvalB_sign;
    logic [15:0] binvalA_1_, binvalA_2_, binvalA_3_, binvalA_4_;
    logic [15:0] binvalB_1_, binvalB_2_, binvalB_3_, binvalB_4_;
    logic        sign_out, result_valid, overflow;
    logic [15:0] bin_out_1_, bin_out_2_, bin_out_3_, bin_out_4_;
    logic [63:0] out_mag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        sign;
        logic [63:0] mag;
        logic        ovf;
        int          cyc;
        int          id;
    } exp_t;
    exp_t exp_q[$];

    always #5 s_clk = ~s_clk;
    always @(posedge s_clk) cyc <= cyc + 1;
    assign out_mag = {bin_out_4_, bin_out_3_, bin_out_2_, bin_out_1_};

    ec_prod_sum #(.ACC_GUARD(8)) dut (
        .s_clk(s_clk), .clr(clr), .datavalid_in(datavalid_in), .clear_ena(clear_ena),
        .trunc_ena(trunc_ena),
        .binvalA_sign(binvalA_sign), .binvalA_1_(binvalA_1_), .binvalA_2_(binvalA_2_),
        .binvalA_3_(binvalA_3_), .binvalA_4_(binvalA_4_),
        .binvalB_sign(binvalB_sign), .binvalB_1_(binvalB_1_), .binvalB_2_(binvalB_2_),
        .binvalB_3_(binvalB_3_), .binvalB_4_(binvalB_4_),
        .sign_out(sign_out), .bin_out_1_(bin_out_1_), .bin_out_2_(bin_out_2_),
        .bin_out_3_(bin_out_3_), .bin_out_4_(bin_out_4_),
        .result_valid(result_valid), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge s_clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result %h with no expectation queued", out_mag);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("r%0d_sign", e.id), 64'(sign_out), 64'(e.sign));
                chk($sformatf("r%0d_mag", e.id), out_mag, e.mag);
                chk($sformatf("r%0d_ovf", e.id), 64'(overflow), 64'(e.ovf));
                chk($sformatf("r%0d_latency", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic pair(input logic ce, input logic tr, input logic sa, input logic [63:0] a,
                        input logic sb, input logic [63:0] b);
        datavalid_in = 1'b1;
        clear_ena    = ce;
        trunc_ena    = tr;
        binvalA_sign = sa;
        {binvalA_4_, binvalA_3_, binvalA_2_, binvalA_1_} = a;
        binvalB_sign = sb;
        {binvalB_4_, binvalB_3_, binvalB_2_, binvalB_1_} = b;
        @(posedge s_clk);
        #1;
        datavalid_in = 1'b0;
        clear_ena    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge s_clk);
            #1;
        end
    endtask

    task automatic clear_only();
        clear_ena = 1'b1;
        @(posedge s_clk);
        #1;
        clear_ena = 1'b0;
    endtask

    // Called just before the last pair is driven: result expected 3 edges later.
    task automatic expect_res(input logic s, input logic [63:0] m, input logic o, input int id);
        exp_t e;
        e.sign = s;
        e.mag  = m;
        e.ovf  = o;
        e.cyc  = cyc + 3;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_valid"}, 64'(result_valid), 64'd0);
        chk({nm, "_sign"}, 64'(sign_out), 64'd0);
        chk({nm, "_mag"}, out_mag, 64'd0);
        chk({nm, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    function automatic logic [63:0] qmag(input real x);
        real ax;
        ax = (x < 0.0) ? -x : x;
        return 64'(longint'(ax * 4294967296.0));
    endfunction

    real av[8] = '{12.3456789, -1.27809987, 56.78099, -10.0, 98.012, 8.099762, 9.777777777, -12.9099876};
    real bv[8] = '{34.908765, 2.034590987, 65.9076554, 23.90876655, 78.0944556, -92.0977623, 12.73455555, 90.98877222};

    localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;
    localparam logic [63:0] TWO   = 64'h0000_0002_0000_0000;
    localparam logic [63:0] THREE = 64'h0000_0003_0000_0000;

    initial begin
        logic [136:0] acc, absv;
        logic [127:0] p;
        logic [63:0]  m8;
        logic         neg8, ovf8;

        clr = 1'b1; datavalid_in = 1'b0; clear_ena = 1'b0; trunc_ena = 1'b1;
        binvalA_sign = 1'b0; binvalB_sign = 1'b0;
        {binvalA_4_, binvalA_3_, binvalA_2_, binvalA_1_} = '0;
        {binvalB_4_, binvalB_3_, binvalB_2_, binvalB_1_} = '0;
        idle(2);
        chk_zero_outputs("reset");
        clr = 1'b0;

        // 2.5 * -4.0 = -10.0
        expect_res(1'b1, 64'h0000_000A_0000_0000, 1'b0, 1);
        pair(1'b1, 1'b1, 1'b0, 64'h0000_0002_8000_0000, 1'b1, 64'h0000_0004_0000_0000);
        idle(4);

        // clr mid-sequence discards the three pending 9s; only 3*2 survives
        pair(1'b0, 1'b1, 1'b0, THREE, 1'b0, THREE);
        pair(1'b0, 1'b1, 1'b0, THREE, 1'b0, THREE);
        pair(1'b0, 1'b1, 1'b0, THREE, 1'b0, THREE);
        clr = 1'b1;
        idle(2);
        chk_zero_outputs("midclr");
        clr = 1'b0;
        expect_res(1'b0, 64'h0000_0006_0000_0000, 1'b0, 2);
        pair(1'b1, 1'b1, 1'b0, THREE, 1'b0, TWO);
        idle(4);

        // 8-term vector, truncating; bit-true expectation from the operand bits
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            p = 128'(qmag(av[i])) * 128'(qmag(bv[i]));
            if ((av[i] < 0.0) != (bv[i] < 0.0)) acc = acc - 137'(p);
            else                                acc = acc + 137'(p);
        end
        neg8 = acc[136];
        absv = neg8 ? -acc : acc;
        ovf8 = |absv[136:96];
        m8   = ovf8 ? 64'hFFFF_FFFF_FFFF_FFFF : absv[95:32];
        for (int i = 0; i < 8; i++) begin
            if (i == 7) expect_res(neg8 & (|m8), m8, ovf8, 3);
            pair(i == 7, 1'b1, av[i] < 0.0, qmag(av[i]), bv[i] < 0.0, qmag(bv[i]));
        end
        idle(2);
        chk("dot8_valid", 64'(result_valid), 64'd1);
        chk("dot8_sign", 64'(sign_out), 64'd0);
        chk("dot8_w4", 64'(bin_out_4_), 64'h0000);
        chk("dot8_w3", 64'(bin_out_3_), 64'h263D);
        chk("dot8_w2", 64'(bin_out_2_), 64'hA96C);
        idle(2);

        // (1 + 2^-32) * 0.5: truncate drops the half LSB, rounding keeps it
        expect_res(1'b0, 64'h0000_0000_8000_0000, 1'b0, 4);
        pair(1'b1, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 64'h0000_0000_8000_0000);
        expect_res(1'b0, 64'h0000_0000_8000_0001, 1'b0, 5);
        pair(1'b1, 1'b0, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 64'h0000_0000_8000_0000);
        // -2^-32 * 0.5: truncates to +0, rounds away from zero to -2^-32
        expect_res(1'b0, 64'd0, 1'b0, 12);
        pair(1'b1, 1'b1, 1'b1, 64'd1, 1'b0, 64'h0000_0000_8000_0000);
        expect_res(1'b1, 64'd1, 1'b0, 13);
        pair(1'b1, 1'b0, 1'b1, 64'd1, 1'b0, 64'h0000_0000_8000_0000);
        idle(4);

        // saturation, positive and negative
        expect_res(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6);
        pair(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0, TWO);
        expect_res(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7);
        pair(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0, TWO);
        idle(4);

        // 3*2 + (-6)*1 with a bubble in between: exact zero, positive sign, overflow cleared
        pair(1'b0, 1'b1, 1'b0, THREE, 1'b0, TWO);
        idle(1);
        expect_res(1'b0, 64'd0, 1'b0, 8);
        pair(1'b1, 1'b1, 1'b1, 64'h0000_0006_0000_0000, 1'b0, ONE);
        idle(4);

        // back-to-back: 1*1 + 2*2 = 5, then 3*3 + (-1)*2 = 7
        pair(1'b0, 1'b1, 1'b0, ONE, 1'b0, ONE);
        expect_res(1'b0, 64'h0000_0005_0000_0000, 1'b0, 9);
        pair(1'b1, 1'b1, 1'b0, TWO, 1'b0, TWO);
        pair(1'b0, 1'b1, 1'b0, THREE, 1'b0, THREE);
        expect_res(1'b0, 64'h0000_0007_0000_0000, 1'b0, 10);
        pair(1'b1, 1'b1, 1'b1, ONE, 1'b0, TWO);
        idle(4);

        // standalone clear drops the 7 but not the 5 sitting in stage 1; -0 operand adds nothing
        pair(1'b0, 1'b1, 1'b0, 64'h0000_0007_0000_0000, 1'b0, ONE);
        idle(2);
        pair(1'b0, 1'b1, 1'b0, 64'h0000_0005_0000_0000, 1'b0, ONE);
        clear_only();
        pair(1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 64'h0000_0005_0000_0000);
        expect_res(1'b0, 64'h0000_0009_0000_0000, 1'b0, 11);
        pair(1'b1, 1'b1, 1'b0, TWO, 1'b0, TWO);
        idle(6);

        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
